logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Shares one instance of the pipelined 32-bit `logic_unit` between two requesters (e.g. the two issue slots of the execute stage). Each cycle the block grants at most one requester in round-robin order and registers that requester's operands and opcode onto the logic unit's inputs. It then tracks the in-flight operation through the logic unit's fixed latency and returns the result tagged with the requester ID. It sits between issue logic and `logic_unit`; the logic unit itself is unchanged.

## Interface
- `WIDTH`, 32, operand/result width.
- `LU_LATENCY`, 1, number of clock edges from `lu_a`/`lu_b`/`lu_op` changing to `lu_out` being valid; legal range 1–4.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  requester 0/1 has an operation pending.
- `a0`, `b0`, `a1`, `b1`  in  WIDTH  operands of requester 0/1.
- `op0`, `op1`  in  3  logic-unit opcode of requester 0/1.
- `stall`  in  1  blocks new grants this cycle.
- `gnt0`, `gnt1`  out  1  combinational grant; the operation is accepted at the edge where `reqN & gntN`.
- `lu_a`, `lu_b`  out  WIDTH  registered operands to the logic unit.
- `lu_op`  out  3  registered opcode to the logic unit.
- `lu_out`  in  WIDTH  logic unit result.
- `rsp_valid`  out  1  one-cycle pulse; the result is present.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_data`  out  WIDTH  registered result.
- `busy`  out  1  at least one operation is in flight (issued, no response yet).

## Operation
- **Arbitration:**
  - Combinational from `req0`, `req1`, `stall`, and the priority pointer `prio` (0 or 1).
  - If `stall`=1, then `gnt0` = `gnt1` = 0.
  - If only one request is present, that requester is granted.
  - If both requests are present, requester `prio` is granted.
  - `gnt0` and `gnt1` are never high together.
  - A grant is never asserted without the matching request.
- **Priority pointer:** on every accepted grant, `prio` ← the requester that was not granted. With no grant, `prio` holds.
- **Issue:** at the accept edge, `lu_a`/`lu_b`/`lu_op` ← the granted requester's `a`/`b`/`op`. With no grant, they hold their previous values; no toggling.
- **Tag pipe:**
  - Shift register of depth `LU_LATENCY`; each entry is {valid, id}.
  - Stage 0 loads {1, granted id} on accept, otherwise {0, x}.
  - All stages shift every cycle, independent of `stall`.
- **Retire:**
  - When the last tag stage is valid, at the next edge: `rsp_data` ← `lu_out`, `rsp_id` ← tag id, `rsp_valid` ← 1.
  - Otherwise `rsp_valid` ← 0, and `rsp_data`/`rsp_id` hold.
- **Pipelining:** back-to-back grants are allowed every cycle; up to `LU_LATENCY`+1 operations can be in flight. There is no response backpressure.
- **`busy`:** OR of all tag-pipe valid bits, plus the retire stage about to assert `rsp_valid`.

## Timing
- **Reset values:** `gnt0`=`gnt1`=0 while `reset` is high; `lu_a`=`lu_b`=0; `lu_op`=3'b000; `rsp_valid`=0; `rsp_id`=0; `rsp_data`=0; `busy`=0; `prio`=0; all tag entries invalid.
- **Latency:** accept at edge E → `rsp_valid` high during the cycle after edge E+`LU_LATENCY`+1. For `LU_LATENCY`=1 that is 2 cycles.
- **Throughput:** one accept per cycle. Responses come out in grant order, one per cycle, with no gaps for back-to-back grants.
- **Stall:** `stall` affects only new grants. In-flight operations complete and respond on schedule.
- **Simultaneous events:**
  - A grant and a retire in the same cycle are independent.
  - A request dropped while not granted is lost; no state is kept for it.
- **Reset mid-operation:** asynchronous clear of all state. In-flight operations are discarded and produce no `rsp_valid` after reset deasserts. The first grant after reset favours requester 0.

## Test plan
Bench uses a behavioural logic unit stub with latency `LU_LATENCY`, computing `lu_out` = `lu_a` ^ `lu_b` ^ {29'b0, `lu_op`}.

- **Single request:** `req0`=1 for 1 cycle with `a0`=32'hF0F0F0FF, `b0`=32'h0F0F0F0F, `op0`=3'b110, `LU_LATENCY`=1 → `gnt0`=1 that cycle; 2 cycles later `rsp_valid`=1 for 1 cycle, `rsp_id`=0, `rsp_data`=32'hFFFFFFF6.
- **Contention:** `req0`=`req1`=1 held for 4 cycles → grants alternate 0,1,0,1; 4 responses on consecutive cycles with `rsp_id` 0,1,0,1.
- **Stall:** both requesting with `stall`=1 for 3 cycles → no grants, `busy`=0. Then `stall`=0 → requester `prio` is granted first.
- **Stall during flight:** grant `req1`, then raise `stall` the next cycle → the response still arrives on schedule with `rsp_id`=1.
- **Reset mid-flight:** assert `reset` one cycle after a grant → no `rsp_valid` afterwards, all outputs at reset values, first post-reset grant goes to requester 0.
- **Latency sweep:** `LU_LATENCY`=3, back-to-back grants → `rsp_valid` starts 4 cycles after the first accept, in-order data, `busy` high throughout.

Source files
------------

// File: rtl/logic_unit_arbiter_if.sv
// Issue/response bundle between the two requesters, the arbiter and the shared logic unit.
// slave is the arbiter's view; master is the requester/logic-unit side.
interface logic_unit_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [2:0]       op0;
  logic [2:0]       op1;
  logic             stall;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] lu_a;
  logic [WIDTH-1:0] lu_b;
  logic [2:0]       lu_op;
  logic [WIDTH-1:0] lu_out;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1, stall, lu_out,
    output gnt0, gnt1, lu_a, lu_b, lu_op, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1, stall, lu_out,
    input  gnt0, gnt1, lu_a, lu_b, lu_op, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of one pipelined logic unit between two requesters,
// with an id tag pipe that returns each result to its owner.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LU_LATENCY = 1
) (
  input logic                  clk,
  input logic                  reset,
  logic_unit_arbiter_if.slave  bus
);

  // One extra stage covers the lu_a/lu_b/lu_op input register ahead of the unit.
  localparam int unsigned DEPTH = LU_LATENCY + 1;

  logic             prio;
  logic             g0;
  logic             g1;
  logic             accept;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [2:0]       op_sel;
  logic [DEPTH-1:0] tag_vld;
  logic [DEPTH-1:0] tag_id;
  logic [DEPTH-1:0] tag_vld_d;
  logic [DEPTH-1:0] tag_id_d;

  // Grant: a lone requester wins; on contention prio wins. Nothing during stall or reset.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset && !bus.stall) begin
      if (bus.req0 && (!bus.req1 || !prio)) g0 = 1'b1;
      else if (bus.req1)                   g1 = 1'b1;
    end
  end

  assign accept   = g0 | g1;
  assign bus.gnt0 = g0;
  assign bus.gnt1 = g1;

  assign a_sel  = g1 ? bus.a1  : bus.a0;
  assign b_sel  = g1 ? bus.b1  : bus.b0;
  assign op_sel = g1 ? bus.op1 : bus.op0;

  assign tag_vld_d = {tag_vld[DEPTH-2:0], accept};
  assign tag_id_d  = {tag_id[DEPTH-2:0], g1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio          <= 1'b0;
      bus.lu_a      <= '0;
      bus.lu_b      <= '0;
      bus.lu_op     <= 3'b000;
      tag_vld       <= '0;
      tag_id        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      if (accept) begin
        prio      <= ~g1;
        bus.lu_a  <= a_sel;
        bus.lu_b  <= b_sel;
        bus.lu_op <= op_sel;
      end
      tag_vld       <= tag_vld_d;
      tag_id        <= tag_id_d;
      bus.busy      <= |tag_vld_d;
      bus.rsp_valid <= tag_vld[DEPTH-1];
      if (tag_vld[DEPTH-1]) begin
        bus.rsp_data <= bus.lu_out;
        bus.rsp_id   <= tag_id[DEPTH-1];
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: one instance at latency 1, one at latency 3,
// each driving a behavioural logic unit stub.
module tb_logic_unit_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.WIDTH(32)) bus1 ();
  logic_unit_arbiter_if #(.WIDTH(32)) bus3 ();

  logic_unit_arbiter #(.WIDTH(32), .LU_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  logic_unit_arbiter #(.WIDTH(32), .LU_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  function automatic logic [31:0] lu_f(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op);
    return a ^ b ^ {29'b0, op};
  endfunction

  // Logic unit stubs: latency 1 and latency 3
  logic [31:0] p3 [3];
  always @(posedge clk) bus1.lu_out <= lu_f(bus1.lu_a, bus1.lu_b, bus1.lu_op);
  always @(posedge clk) begin
    p3[0] <= lu_f(bus3.lu_a, bus3.lu_b, bus3.lu_op);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus3.lu_out = p3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  logic [31:0] cexp [4];
  logic [31:0] sexp [3];

  initial begin
    cexp = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0102, 32'h0000_0202};
    sexp = '{32'h0000_1001, 32'h0000_2001, 32'h0000_3001};
    reset = 1'b1;
    bus1.req0 = 0; bus1.req1 = 0; bus1.stall = 0;
    bus1.a0 = 0; bus1.b0 = 0; bus1.a1 = 0; bus1.b1 = 0; bus1.op0 = 0; bus1.op1 = 0;
    bus3.req0 = 0; bus3.req1 = 0; bus3.stall = 0;
    bus3.a0 = 0; bus3.b0 = 0; bus3.a1 = 0; bus3.b1 = 0; bus3.op0 = 0; bus3.op1 = 0;

    // Reset state, grants suppressed while reset is high
    @(negedge clk);
    bus1.req0 = 1; bus1.req1 = 1;
    #1;
    chk("rst_gnt0", bus1.gnt0, 0);
    chk("rst_gnt1", bus1.gnt1, 0);
    chk("rst_lu_a", bus1.lu_a, 0);
    chk("rst_lu_op", bus1.lu_op, 0);
    chk("rst_rsp_valid", bus1.rsp_valid, 0);
    chk("rst_rsp_id", bus1.rsp_id, 0);
    chk("rst_rsp_data", bus1.rsp_data, 0);
    chk("rst_busy", bus1.busy, 0);
    @(negedge clk);
    bus1.req0 = 0; bus1.req1 = 0;
    reset = 1'b0;

    // Single request from requester 0
    @(negedge clk);
    bus1.req0 = 1; bus1.a0 = 32'hF0F0F0FF; bus1.b0 = 32'h0F0F0F0F; bus1.op0 = 3'b110;
    #1;
    chk("single_gnt0", bus1.gnt0, 1);
    chk("single_gnt1", bus1.gnt1, 0);
    @(negedge clk);
    bus1.req0 = 0;
    chk("single_lu_a", bus1.lu_a, 32'hF0F0F0FF);
    chk("single_lu_op", bus1.lu_op, 3'b110);
    chk("single_busy1", bus1.busy, 1);
    chk("single_early", bus1.rsp_valid, 0);
    @(negedge clk);
    chk("single_busy2", bus1.busy, 1);
    chk("single_early2", bus1.rsp_valid, 0);
    @(negedge clk);
    chk("single_rsp_valid", bus1.rsp_valid, 1);
    chk("single_rsp_id", bus1.rsp_id, 0);
    chk("single_rsp_data", bus1.rsp_data, 32'hFFFFFFF6);
    chk("single_busy_done", bus1.busy, 0);
    @(negedge clk);
    chk("single_pulse_end", bus1.rsp_valid, 0);
    chk("single_data_hold", bus1.rsp_data, 32'hFFFFFFF6);

    // Grant requester 1, then stall while it is in flight
    bus1.req1 = 1; bus1.a1 = 32'h12345678; bus1.b1 = 32'h0000FFFF; bus1.op1 = 3'b011;
    #1;
    chk("sflt_gnt1", bus1.gnt1, 1);
    chk("sflt_gnt0", bus1.gnt0, 0);
    @(negedge clk);
    bus1.req1 = 0; bus1.stall = 1;
    chk("sflt_busy", bus1.busy, 1);
    @(negedge clk);
    chk("sflt_early", bus1.rsp_valid, 0);
    @(negedge clk);
    chk("sflt_rsp_valid", bus1.rsp_valid, 1);
    chk("sflt_rsp_id", bus1.rsp_id, 1);
    chk("sflt_rsp_data", bus1.rsp_data, 32'h1234A984);

    // Both requesting under stall: no grants, idle
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      bus1.req0 = 1; bus1.req1 = 1; bus1.stall = 1;
      #1;
      chk("stall_gnt0", bus1.gnt0, 0);
      chk("stall_gnt1", bus1.gnt1, 0);
      chk("stall_busy", bus1.busy, 0);
    end

    // Release stall and hold contention for 4 cycles
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus1.stall = 0;
      if (c >= 1 && c <= 5) chk("cont_busy", bus1.busy, 1);
      chk("cont_rsp_valid", bus1.rsp_valid, 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        chk("cont_rsp_id", bus1.rsp_id, 32'((c - 3) % 2));
        chk("cont_rsp_data", bus1.rsp_data, cexp[c-3]);
      end
      if (c < 4) begin
        bus1.req0 = 1; bus1.req1 = 1;
        bus1.a0 = 32'h100 + 32'(c); bus1.b0 = 0; bus1.op0 = 3'b000;
        bus1.a1 = 32'h200 + 32'(c); bus1.b1 = 0; bus1.op1 = 3'b001;
        #1;
        chk("cont_gnt0", bus1.gnt0, 32'(c % 2 == 0));
        chk("cont_gnt1", bus1.gnt1, 32'(c % 2 == 1));
      end else begin
        bus1.req0 = 0; bus1.req1 = 0;
      end
    end

    // Reset one cycle after a grant discards the in-flight op
    @(negedge clk);
    bus1.req0 = 1; bus1.a0 = 32'hDEADBEEF; bus1.b0 = 0; bus1.op0 = 3'b000;
    #1;
    chk("rmid_gnt0", bus1.gnt0, 1);
    @(negedge clk);
    bus1.req0 = 0;
    reset = 1'b1;
    #1;
    chk("rmid_rsp_valid", bus1.rsp_valid, 0);
    chk("rmid_busy", bus1.busy, 0);
    chk("rmid_lu_a", bus1.lu_a, 0);
    chk("rmid_lu_b", bus1.lu_b, 0);
    chk("rmid_lu_op", bus1.lu_op, 0);
    chk("rmid_rsp_id", bus1.rsp_id, 0);
    chk("rmid_rsp_data", bus1.rsp_data, 0);
    bus1.req0 = 1; bus1.req1 = 1;
    #1;
    chk("rmid_gnt0_in_rst", bus1.gnt0, 0);
    chk("rmid_gnt1_in_rst", bus1.gnt1, 0);
    @(negedge clk);
    reset = 1'b0;
    bus1.req0 = 0; bus1.req1 = 0;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      chk("rmid_no_rsp", bus1.rsp_valid, 0);
      chk("rmid_idle", bus1.busy, 0);
    end
    bus1.req0 = 1; bus1.req1 = 1;
    #1;
    chk("rmid_first_gnt0", bus1.gnt0, 1);
    chk("rmid_first_gnt1", bus1.gnt1, 0);
    @(negedge clk);
    bus1.req0 = 0; bus1.req1 = 0;
    repeat (3) @(negedge clk);

    // Latency 3 instance, three back-to-back grants
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 6) chk("sweep_busy", bus3.busy, 1);
      chk("sweep_rsp_valid", bus3.rsp_valid, 32'(c >= 5 && c <= 7));
      if (c >= 5 && c <= 7) begin
        chk("sweep_rsp_id", bus3.rsp_id, 0);
        chk("sweep_rsp_data", bus3.rsp_data, sexp[c-5]);
      end
      if (c < 3) begin
        bus3.req0 = 1; bus3.a0 = 32'h1000 * 32'(c + 1); bus3.b0 = 32'h1; bus3.op0 = 3'b000;
        #1;
        chk("sweep_gnt0", bus3.gnt0, 1);
      end else begin
        bus3.req0 = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
